// File: rtl/dma_rd_arbiter_if.sv
// Client-side and dma_read-side signals of the shared read-engine arbiter.
// slave = arbiter view, master = clients/engine view.
interface dma_rd_arbiter_if #(
  parameter int NUM_REQ      = 4,
  parameter int BITS_TRANS   = 18,
  parameter int AXI_WIDTH_AD = 32,
  parameter int AXI_WIDTH_DA = 32
);
  localparam int OW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]              req_valid;
  logic [NUM_REQ-1:0]              req_ready;
  logic [NUM_REQ*AXI_WIDTH_AD-1:0] req_addr;
  logic [NUM_REQ*BITS_TRANS-1:0]   req_len;
  logic [AXI_WIDTH_DA-1:0]         rd_data;
  logic [NUM_REQ-1:0]              rd_vld;
  logic [BITS_TRANS-1:0]           rd_cnt;
  logic [NUM_REQ-1:0]              req_done;
  logic                            busy;
  logic [OW-1:0]                   owner;
  logic                            err;
  logic                            dma_start;
  logic [BITS_TRANS-1:0]           dma_num_trans;
  logic [AXI_WIDTH_AD-1:0]         dma_start_addr;
  logic [AXI_WIDTH_DA-1:0]         dma_data;
  logic                            dma_data_vld;
  logic                            dma_done;

  modport slave (
    input  req_valid, req_addr, req_len, dma_data, dma_data_vld, dma_done,
    output req_ready, rd_data, rd_vld, rd_cnt, req_done, busy, owner, err,
           dma_start, dma_num_trans, dma_start_addr
  );

  modport master (
    output req_valid, req_addr, req_len, dma_data, dma_data_vld, dma_done,
    input  req_ready, rd_data, rd_vld, rd_cnt, req_done, busy, owner, err,
           dma_start, dma_num_trans, dma_start_addr
  );
endinterface

// File: rtl/dma_rd_arbiter.sv
// Shares one dma_read engine among NUM_REQ clients: grant, start, beat steering, completion.
// Define DMA_RD_ARB_RR_EN for round-robin grants; default is fixed priority (lowest index).
module dma_rd_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int BITS_TRANS   = 18,
  parameter int AXI_WIDTH_AD = 32,
  parameter int AXI_WIDTH_DA = 32,
  parameter int GAP_CYCLES   = 4
) (
  input logic              clk,
  input logic              rstn,
  dma_rd_arbiter_if.slave  bus
);
  localparam int OW = $clog2(NUM_REQ);
  localparam int GW = $clog2(GAP_CYCLES + 1);

  typedef enum logic [2:0] {IDLE, ISSUE, BUSY, DONE, GAP} state_t;

  state_t                  r_state;
  logic [OW-1:0]           r_owner;
  logic [AXI_WIDTH_AD-1:0] r_addr;
  logic [BITS_TRANS-1:0]   r_len;
  logic [BITS_TRANS-1:0]   r_beat_cnt;
  logic [GW-1:0]           r_gap;
  logic                    r_start;
  logic                    r_busy;
  logic                    r_err;
  logic [NUM_REQ-1:0]      r_done;

  logic                    w_any;
  logic                    w_grant;
  logic [OW-1:0]           w_gnt;
  logic [NUM_REQ-1:0]      w_req_ready;
  logic [NUM_REQ-1:0]      w_rd_vld;
  logic [AXI_WIDTH_AD-1:0] w_addr;
  logic [BITS_TRANS-1:0]   w_len;

`ifdef DMA_RD_ARB_RR_EN
  logic [OW-1:0] r_ptr;

  function automatic logic [OW-1:0] rr_idx(input logic [OW-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return OW'(s);
  endfunction

  // Scan downward so the smallest offset from the pointer wins.
  always_comb begin
    w_any = 1'b0;
    w_gnt = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (bus.req_valid[rr_idx(r_ptr, k)]) begin
        w_any = 1'b1;
        w_gnt = rr_idx(r_ptr, k);
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_ptr <= '0;
    end else if (w_grant) begin
      r_ptr <= (w_gnt == OW'(NUM_REQ - 1)) ? '0 : w_gnt + 1'b1;
    end
  end
`else
  always_comb begin
    w_any = 1'b0;
    w_gnt = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (bus.req_valid[i]) begin
        w_any = 1'b1;
        w_gnt = OW'(i);
      end
    end
  end
`endif

  assign w_grant = (r_state == IDLE) && w_any;
  assign w_addr  = bus.req_addr[w_gnt*AXI_WIDTH_AD +: AXI_WIDTH_AD];
  assign w_len   = bus.req_len[w_gnt*BITS_TRANS +: BITS_TRANS];

  always_comb begin
    w_req_ready = '0;
    if (w_grant) w_req_ready[w_gnt] = 1'b1;
  end

  // Beats pass straight through to the owner; anything outside BUSY is dropped.
  always_comb begin
    w_rd_vld = '0;
    if ((r_state == BUSY) && bus.dma_data_vld) w_rd_vld[r_owner] = 1'b1;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state    <= IDLE;
      r_owner    <= '0;
      r_addr     <= '0;
      r_len      <= '0;
      r_beat_cnt <= '0;
      r_gap      <= '0;
      r_start    <= 1'b0;
      r_busy     <= 1'b0;
      r_err      <= 1'b0;
      r_done     <= '0;
    end else begin
      r_start <= 1'b0;
      r_done  <= '0;
      case (r_state)
        IDLE: begin
          if (w_grant) begin
            r_owner    <= w_gnt;
            r_addr     <= w_addr;
            r_len      <= w_len;
            r_beat_cnt <= '0;
            r_busy     <= 1'b1;
            if (w_len == '0) begin
              r_state        <= DONE;
              r_done[w_gnt]  <= 1'b1;
            end else begin
              r_state <= ISSUE;
              r_start <= 1'b1;
            end
          end
        end
        ISSUE: r_state <= BUSY;
        BUSY: begin
          if (bus.dma_data_vld) r_beat_cnt <= r_beat_cnt + 1'b1;
          if (bus.dma_done) begin
            r_state         <= DONE;
            r_done[r_owner] <= 1'b1;
          end
        end
        DONE: begin
          if (r_beat_cnt != r_len) r_err <= 1'b1;
          r_gap   <= GW'(GAP_CYCLES);
          r_state <= GAP;
        end
        // Engine needs GAP_CYCLES idle cycles before it can see another start.
        GAP: begin
          if (r_gap <= GW'(1)) begin
            r_gap   <= '0;
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_gap <= r_gap - 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.req_ready      = w_req_ready;
  assign bus.rd_vld         = w_rd_vld;
  assign bus.rd_data        = (r_state == BUSY) ? bus.dma_data : '0;
  assign bus.rd_cnt         = r_beat_cnt;
  assign bus.req_done       = r_done;
  assign bus.busy           = r_busy;
  assign bus.owner          = r_owner;
  assign bus.err            = r_err;
  assign bus.dma_start      = r_start;
  assign bus.dma_num_trans  = r_len;
  assign bus.dma_start_addr = r_addr;
endmodule

// File: tb/tb_dma_rd_arbiter.sv
// Scoreboard bench for dma_rd_arbiter: random clients, behavioural dma_read engine model,
// reference arbitration from the grant rules, monitors popping expected grants/beats/dones.
module tb_dma_rd_arbiter;
  localparam int N   = 4;
  localparam int BT  = 18;
  localparam int AD  = 32;
  localparam int DA  = 32;
  localparam int GAP = 4;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  dma_rd_arbiter_if #(.NUM_REQ(N), .BITS_TRANS(BT), .AXI_WIDTH_AD(AD), .AXI_WIDTH_DA(DA)) bus();

  dma_rd_arbiter #(.NUM_REQ(N), .BITS_TRANS(BT), .AXI_WIDTH_AD(AD), .AXI_WIDTH_DA(DA),
                   .GAP_CYCLES(GAP)) dut (.clk(clk), .rstn(rstn), .bus(bus));

  typedef struct {int c; logic [AD-1:0] a; logic [BT-1:0] l;} job_t;
  typedef struct {int c; bit zero; int gcyc;} done_t;
  typedef struct {int c; logic [DA-1:0] d; int idx;} beat_t;

  job_t  exp_start_q[$];
  done_t exp_done_q[$];
  beat_t exp_beat_q[$];
  int    grant_log[$];

`ifdef DMA_RD_ARB_RR_EN
  int exp_order[8] = '{0, 1, 2, 3, 0, 2, 0, 2};
  int rpt_jobs = 3;
`else
  int exp_order[4] = '{0, 1, 2, 3};
  int rpt_jobs = 1;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int ref_ptr  = 0;
  int last_done_cyc = 0;
  bit have_done = 0;
  int last_reqdone_cyc = 0;
  bit reqdone_seen = 0;
  int short_by = 0;
  bit abort = 0;
  int beats_sent = 0;
  bit prev_start = 0;
  bit prev_busy = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference arbitration: first pending client scanning from ptr (ptr stays 0 for fixed priority).
  function automatic int ref_pick(input logic [N-1:0] pend, input int ptr);
    for (int k = 0; k < N; k++) begin
      int i;
      i = (ptr + k) % N;
      if (pend[i]) return i;
    end
    return -1;
  endfunction

  always @(negedge clk) begin : monitor
    int g;
    beat_t b;
    done_t e;
    job_t j;
    if (bus.req_ready != '0) begin
      g = ref_pick(bus.req_valid, ref_ptr);
      check("grant", 64'(bus.req_ready), (g < 0) ? 64'd0 : (64'd1 << g));
      if (g >= 0) begin
        grant_log.push_back(g);
`ifdef DMA_RD_ARB_RR_EN
        ref_ptr = (g + 1) % N;
`endif
        j.c = g;
        j.a = bus.req_addr[g*AD +: AD];
        j.l = bus.req_len[g*BT +: BT];
        if (j.l != '0) exp_start_q.push_back(j);
        e.c = g; e.zero = (j.l == '0); e.gcyc = cyc;
        exp_done_q.push_back(e);
      end
    end
    if (exp_beat_q.size() > 0) begin
      b = exp_beat_q.pop_front();
      check("rd_vld", 64'(bus.rd_vld), 64'd1 << b.c);
      check("rd_data", 64'(bus.rd_data), 64'(b.d));
      check("rd_cnt", 64'(bus.rd_cnt), 64'(b.idx));
    end else if (bus.rd_vld != '0) begin
      check("rd_vld_stray", 64'(bus.rd_vld), 64'd0);
    end
    if (bus.req_done != '0) begin
      if (exp_done_q.size() == 0) begin
        check("req_done_stray", 64'(bus.req_done), 64'd0);
      end else begin
        e = exp_done_q.pop_front();
        check("req_done", 64'(bus.req_done), 64'd1 << e.c);
        check("done_latency", 64'(cyc), e.zero ? 64'(e.gcyc + 1) : 64'(last_done_cyc + 1));
        last_reqdone_cyc = cyc;
        reqdone_seen = 1;
      end
    end
    if (prev_busy && !bus.busy && rstn && reqdone_seen) begin
      check("busy_fall", 64'(cyc - last_reqdone_cyc), 64'(GAP + 1));
      reqdone_seen = 0;
    end
    if (prev_start) check("start_single", 64'(bus.dma_start), 64'd0);
    prev_start = bus.dma_start;
    prev_busy  = bus.busy;
  end

  // Behavioural dma_read: on start, emit beats with random idle gaps, then done.
  initial begin : dma_model
    bus.dma_data     = '0;
    bus.dma_data_vld = 1'b0;
    bus.dma_done     = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.dma_start && rstn) begin : job
        job_t j;
        int nb;
        int idle;
        if (exp_start_q.size() == 0) begin
          check("dma_start_stray", 64'd1, 64'd0);
          j.c = 0; j.a = '0; j.l = '0;
        end else begin
          j = exp_start_q.pop_front();
          check("dma_addr", 64'(bus.dma_start_addr), 64'(j.a));
          check("dma_num", 64'(bus.dma_num_trans), 64'(j.l));
        end
        if (have_done) check("dma_gap_ok", 64'((cyc - last_done_cyc) >= GAP + 3), 64'd1);
        nb = int'(j.l) - short_by;
        if (nb < 0) nb = 0;
        beats_sent = 0;
        for (int b = 0; b < nb; b++) begin
          idle = $urandom_range(0, 2);
          for (int k = 0; k <= idle; k++) begin
            @(posedge clk); #1;
            bus.dma_data_vld = 1'b0;
            if (abort) break;
          end
          if (abort) break;
          bus.dma_data     = $urandom;
          bus.dma_data_vld = 1'b1;
          exp_beat_q.push_back('{j.c, bus.dma_data, b});
          beats_sent++;
        end
        if (!abort && (nb == 0 || $urandom_range(0, 1) == 0)) begin
          @(posedge clk); #1;
          bus.dma_data_vld = 1'b0;
        end
        if (!abort) begin
          bus.dma_done  = 1'b1;
          last_done_cyc = cyc;
          have_done     = 1;
          @(posedge clk); #1;
        end
        bus.dma_data_vld = 1'b0;
        bus.dma_done     = 1'b0;
      end
    end
  end

  task automatic client_job(input int c, input logic [AD-1:0] a, input logic [BT-1:0] l);
    int t;
    @(posedge clk); #1;
    bus.req_addr[c*AD +: AD] = a;
    bus.req_len[c*BT +: BT]  = l;
    bus.req_valid[c]         = 1'b1;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!bus.req_ready[c] && t < 5000);
    if (t >= 5000) check("grant_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
    bus.req_valid[c] = 1'b0;
  endtask

  task automatic client_rpt(input int c, input int n);
    for (int j = 0; j < n; j++) client_job(c, AD'(32'h0001_0000 * (c + 1) + 32'h100 * j), BT'(16));
  endtask

  task automatic client_rand(input int c);
    int n;
    n = $urandom_range(1, 3);
    for (int j = 0; j < n; j++) client_job(c, AD'($urandom) & ~AD'(3), BT'($urandom_range(0, 24)));
  endtask

  task automatic wait_quiet(input int budget);
    int t;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while ((bus.req_valid != '0 || bus.busy || exp_done_q.size() != 0) && t < budget);
    if (t >= budget) check("quiet_timeout", 64'd0, 64'd1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"},     64'(bus.busy), 64'd0);
    check({tag, "_start"},    64'(bus.dma_start), 64'd0);
    check({tag, "_req_done"}, 64'(bus.req_done), 64'd0);
    check({tag, "_rd_vld"},   64'(bus.rd_vld), 64'd0);
    check({tag, "_owner"},    64'(bus.owner), 64'd0);
    check({tag, "_err"},      64'(bus.err), 64'd0);
    check({tag, "_rd_cnt"},   64'(bus.rd_cnt), 64'd0);
    check({tag, "_num"},      64'(bus.dma_num_trans), 64'd0);
    check({tag, "_addr"},     64'(bus.dma_start_addr), 64'd0);
    check({tag, "_ready"},    64'(bus.req_ready), 64'd0);
  endtask

  initial begin : main
    int t;
    rstn          = 1'b0;
    bus.req_valid = '0;
    bus.req_addr  = '0;
    bus.req_len   = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    @(posedge clk); #1;
    rstn = 1'b1;

    // Contention: all four valid together
    grant_log.delete();
    fork
      client_rpt(0, rpt_jobs);
      client_rpt(1, 1);
      client_rpt(2, rpt_jobs);
      client_rpt(3, 1);
    join
    wait_quiet(5000);
    check("order_len", 64'(grant_log.size()), 64'($size(exp_order)));
    for (int i = 0; i < $size(exp_order) && i < grant_log.size(); i++)
      check("order", 64'(grant_log[i]), 64'(exp_order[i]));

    // Single long job
    client_job(1, 32'h0000_1000, 18'd300);
    wait_quiet(5000);
    check("err_single", 64'(bus.err), 64'd0);

    // Zero-length job
    client_job(2, 32'h0000_2000, 18'd0);
    wait_quiet(200);
    check("err_zero", 64'(bus.err), 64'd0);

    // Stray engine inputs while idle
    @(posedge clk); #1;
    bus.dma_data_vld = 1'b1;
    bus.dma_done     = 1'b1;
    bus.dma_data     = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    bus.dma_data_vld = 1'b0;
    bus.dma_done     = 1'b0;
    @(negedge clk);
    check("stray_busy", 64'(bus.busy), 64'd0);
    check("stray_owner", 64'(bus.owner), 64'(grant_log[grant_log.size()-1]));
    check("stray_err", 64'(bus.err), 64'd0);

    // Beat-count mismatch sets sticky err
    short_by = 2;
    client_job(0, 32'h0000_3000, 18'd12);
    wait_quiet(500);
    short_by = 0;
    check("err_mismatch", 64'(bus.err), 64'd1);
    client_job(3, 32'h0000_4000, 18'd20);
    wait_quiet(500);
    check("err_sticky", 64'(bus.err), 64'd1);

    // Random traffic from all clients
    fork
      client_rand(0);
      client_rand(1);
      client_rand(2);
      client_rand(3);
    join
    wait_quiet(8000);
    check("err_sticky_rand", 64'(bus.err), 64'd1);

    // Reset in the middle of a transfer
    beats_sent = 0;
    client_job(3, 32'h0000_5000, 18'd64);
    t = 0;
    while (beats_sent < 5 && t < 2000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 2000) check("beat_timeout", 64'd0, 64'd1);
    #1;
    abort            = 1;
    rstn             = 1'b0;
    bus.dma_data_vld = 1'b0;
    bus.dma_done     = 1'b0;
    @(negedge clk);
    check_all_zero("midrst");
    exp_done_q.delete();
    exp_start_q.delete();
    exp_beat_q.delete();
    ref_ptr      = 0;
    have_done    = 0;
    reqdone_seen = 0;
    repeat (2) @(posedge clk);
    #1;
    rstn  = 1'b1;
    abort = 0;
    client_job(1, 32'h0000_6000, 18'd8);
    wait_quiet(500);
    check("err_after_rst", 64'(bus.err), 64'd0);
    check("queues_empty", 64'(exp_done_q.size() + exp_start_q.size() + exp_beat_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/dma_rd_arbiter.md
Name: dma_rd_arbiter

Overview:
- Shares one dma_read engine among NUM_REQ load clients (weight loader, ifmap loader, bias loader, ...).
- Accepts per-client read jobs (start address, word count) and arbitrates between them.
- Issues one start_dma pulse per job, steers returned beats to the owning client only, and signals per-client completion.
- Enforces the engine's required idle gap between jobs so no start pulse is lost.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- BITS_TRANS, 18, width of job word count; matches dma_read num_trans
- AXI_WIDTH_AD, 32, address width
- AXI_WIDTH_DA, 32, data width
- GAP_CYCLES, 4, idle cycles after job completion before the next dma_start (≥4)

Ports:
- clk  in  1  clock
- rstn  in  1  async active-low reset
- req_valid  in  NUM_REQ  job request per client; held until req_ready
- req_ready  out  NUM_REQ  one-hot job accept
- req_addr  in  NUM_REQ*AXI_WIDTH_AD  packed start byte addresses, client i at [i*AD +: AD]
- req_len  in  NUM_REQ*BITS_TRANS  packed 32-bit word counts
- rd_data  out  AXI_WIDTH_DA  beat data, broadcast to all clients
- rd_vld  out  NUM_REQ  one-hot beat valid to owner
- rd_cnt  out  BITS_TRANS  beat index within current job, 0-based
- req_done  out  NUM_REQ  one-cycle completion pulse to owner
- busy  out  1  high outside IDLE
- owner  out  $clog2(NUM_REQ)  current/last granted client index
- err  out  1  sticky beat-count mismatch; cleared by reset only
- dma_start  out  1  to dma_read start_dma
- dma_num_trans  out  BITS_TRANS  to dma_read num_trans
- dma_start_addr  out  AXI_WIDTH_AD  to dma_read start_addr
- dma_data  in  AXI_WIDTH_DA  from dma_read data_o
- dma_data_vld  in  1  from dma_read data_vld_o
- dma_done  in  1  from dma_read done_o

Behaviour:
- Reset: all outputs 0; state IDLE; RR pointer 0; gap counter 0. Reset asserted mid-job aborts immediately (no req_done). The system must also reset dma_read.
- IDLE:
  - If any req_valid is high, pick grant g and drive req_ready[g]=1 combinationally in that cycle.
  - Latch addr_q, len_q, owner=g.
  - len==0 → DONE without any dma_start. Otherwise → ISSUE.
  - No req_valid → stay.
- ISSUE: dma_start=1 for exactly one cycle → BUSY.
- dma_num_trans=len_q and dma_start_addr=addr_q are held stable from ISSUE until the next grant.
- BUSY:
  - rd_vld[owner]=dma_data_vld and rd_data=dma_data, combinational, zero added latency.
  - rd_vld=0 in all other states and for non-owners.
  - Beat counter increments per forwarded beat; rd_cnt is its value before increment.
  - dma_done (may coincide with the last beat; that beat is still forwarded) → DONE.
- DONE:
  - req_done[owner]=1 for one cycle.
  - If the beat count ≠ len_q, set err (for len 0, count must be 0).
  - Load gap counter = GAP_CYCLES → GAP.
- GAP: decrement each cycle; at 0 → IDLE. busy stays high; req_ready=0.
- Arbitration (default, fixed priority): lowest index with req_valid wins.
- Widths: rd_cnt and the beat counter are BITS_TRANS wide with no wrap check beyond err. owner is updated only at grant.
- Simultaneous events:
  - A new req_valid during BUSY/GAP waits.
  - dma_done outside BUSY is ignored.
  - dma_data_vld outside BUSY is dropped.

Optional Feature:
- Macro DMA_RD_ARB_RR_EN.
- Defined: round-robin arbitration. Search starts at (last_grant+1) mod NUM_REQ; the pointer updates on each grant, including len 0 jobs.
- Undefined: fixed priority, lowest index wins; no pointer register.

Test Plan:
- Single job: client1 addr 0x0000_1000, len 300 → one dma_start pulse with addr 0x1000 / num 300. Exactly 300 rd_vld[1] pulses with rd_cnt 0..299 and rd_vld[0,2,3]=0. req_done[1] one cycle after dma_done; busy falls GAP_CYCLES+1 cycles after DONE; err=0.
- Zero length: client2 len 0 → req_ready[2] pulse, req_done[2] next cycle, no dma_start, err=0.
- Contention, all 4 valid with len 16 each:
  - Without RR: grant order 0,1,2,3.
  - With DMA_RD_ARB_RR_EN and clients 0 and 2 re-requesting continuously: order 0,1,2,3,0,2,0,2.
  - Consecutive dma_start pulses are ≥ GAP_CYCLES+3 cycles after the prior dma_done.
- Mismatch: len 12, model emits 10 beats then dma_done → req_done pulses, err=1 and stays 1 across later good jobs.
- Stray inputs: dma_data_vld and dma_done pulsed while IDLE → no rd_vld, no req_done, state unchanged.
- Reset mid-BUSY after 5 of 64 beats → next cycle all outputs 0 and IDLE. A new request is then served normally with rd_cnt starting at 0.
